// File: rtl/fpu_mem_scheduler.sv
// fpu_mem_scheduler
// Moves whole FPU buffers between memory and the two 512-byte line buffers,
// one LINE_BYTES line at a time. Read (fill) and write (drain) requests are
// single-cycle pulses. Each is held in a one-deep pending slot until the
// memory port is free. Drains take priority over fills. A request that
// arrives while its slot is still occupied is dropped, and the sticky
// overrun flag is set.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   request_read / read_address /  fill request pulse, base byte address,
//   rd_buffer_sel                  target buffer
//   request_write / write_address  drain request pulse, base byte address,
//   / wr_buffer_sel                source buffer
//   clear_err                      clears overrun (a same-cycle set wins)
//   mem_ack                        memory finished the presented line
//   mem_req, mem_we, mem_addr      line transfer request to memory
//   buf_sel, line_idx              buffer and line taking part in the transfer
//   fill_we                        read-buffer line write strobe (mem_ack in READ)
//   making_request                 busy, or holding a pending request
//   overrun                        sticky dropped-request flag
module fpu_mem_scheduler #(
   parameter int LINE_BYTES = 64,
   parameter int BUF_LINES  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         request_read,
   input  logic [31:0]                  read_address,
   input  logic                         rd_buffer_sel,
   input  logic                         request_write,
   input  logic [31:0]                  write_address,
   input  logic                         wr_buffer_sel,
   input  logic                         clear_err,
   input  logic                         mem_ack,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [31:0]                  mem_addr,
   output logic                         buf_sel,
   output logic [$clog2(BUF_LINES)-1:0] line_idx,
   output logic                         fill_we,
   output logic                         making_request,
   output logic                         overrun
);

   localparam int OFS_W = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(BUF_LINES);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BUF_LINES - 1);
   localparam logic [31:0]      LINE_MASK = ~32'(LINE_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Pending request slots
   logic        rd_pend_q, rd_pend_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic        rd_sel_q,  rd_sel_d;
   logic        wr_pend_q, wr_pend_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic        wr_sel_q,  wr_sel_d;

   // Active transfer
   logic [31:0]      base_q, base_d;
   logic             sel_q,  sel_d;
   logic [IDX_W-1:0] idx_q,  idx_d;

   logic overrun_q, overrun_d;

   logic line_ack;
   logic xfer_done;
   logic start_wr;
   logic start_rd;

   // The port is free either when idle or on the acknowledge of the last
   // line. Either way the next transfer launches on that same edge, so
   // back-to-back transfers have no idle cycle between them.
   assign line_ack  = (state_q != IDLE) & mem_ack;
   assign xfer_done = (state_q == IDLE) | (line_ack & (idx_q == LAST_IDX));
   assign start_wr  = xfer_done & wr_pend_q;
   assign start_rd  = xfer_done & ~wr_pend_q & rd_pend_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (start_wr) begin
         state_d = WRITE;
      end else if (start_rd) begin
         state_d = READ;
      end else if (xfer_done) begin
         state_d = IDLE;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      fill_we = 1'b0;
      unique case (state_q)
         WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
         end
         READ: begin
            mem_req = 1'b1;
            fill_we = mem_ack;
         end
         default: begin
         end
      endcase
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      rd_pend_d = rd_pend_q;
      rd_addr_d = rd_addr_q;
      rd_sel_d  = rd_sel_q;
      wr_pend_d = wr_pend_q;
      wr_addr_d = wr_addr_q;
      wr_sel_d  = wr_sel_q;
      base_d    = base_q;
      sel_d     = sel_q;
      idx_d     = idx_q;

      // A start always consumes an occupied slot, and a new pulse is only
      // accepted into an empty one, so the two updates never collide.
      if (start_rd) begin
         rd_pend_d = 1'b0;
      end
      if (request_read && !rd_pend_q) begin
         rd_pend_d = 1'b1;
         rd_addr_d = read_address & LINE_MASK;
         rd_sel_d  = rd_buffer_sel;
      end

      if (start_wr) begin
         wr_pend_d = 1'b0;
      end
      if (request_write && !wr_pend_q) begin
         wr_pend_d = 1'b1;
         wr_addr_d = write_address & LINE_MASK;
         wr_sel_d  = wr_buffer_sel;
      end

      if (start_wr) begin
         base_d = wr_addr_q;
         sel_d  = wr_sel_q;
         idx_d  = '0;
      end else if (start_rd) begin
         base_d = rd_addr_q;
         sel_d  = rd_sel_q;
         idx_d  = '0;
      end else if (xfer_done) begin
         idx_d  = '0;
      end else if (line_ack) begin
         idx_d  = idx_q + 1'b1;
      end

      // Dropping is judged against the slot as it stands before this edge.
      overrun_d = (request_read & rd_pend_q) | (request_write & wr_pend_q) |
                  (overrun_q & ~clear_err);
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend_q <= 1'b0;
         rd_addr_q <= '0;
         rd_sel_q  <= 1'b0;
         wr_pend_q <= 1'b0;
         wr_addr_q <= '0;
         wr_sel_q  <= 1'b0;
         base_q    <= '0;
         sel_q     <= 1'b0;
         idx_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         rd_pend_q <= rd_pend_d;
         rd_addr_q <= rd_addr_d;
         rd_sel_q  <= rd_sel_d;
         wr_pend_q <= wr_pend_d;
         wr_addr_q <= wr_addr_d;
         wr_sel_q  <= wr_sel_d;
         base_q    <= base_d;
         sel_q     <= sel_d;
         idx_q     <= idx_d;
         overrun_q <= overrun_d;
      end
   end

   // Line address wraps modulo 2^32 by plain 32-bit addition.
   assign mem_addr       = base_q + (32'(idx_q) << OFS_W);
   assign buf_sel        = sel_q;
   assign line_idx       = idx_q;
   assign making_request = (state_q != IDLE) | rd_pend_q | wr_pend_q;
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_fpu_mem_scheduler.sv
module tb_fpu_mem_scheduler;

   localparam int LB = 64;
   localparam int BL = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        request_read = 1'b0;
   logic [31:0] read_address = '0;
   logic        rd_buffer_sel = 1'b0;
   logic        request_write = 1'b0;
   logic [31:0] write_address = '0;
   logic        wr_buffer_sel = 1'b0;
   logic        clear_err = 1'b0;
   logic        mem_ack = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic        buf_sel;
   logic [2:0]  line_idx;
   logic        fill_we;
   logic        making_request;
   logic        overrun;

   fpu_mem_scheduler #(.LINE_BYTES(LB), .BUF_LINES(BL)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .request_read   (request_read),
      .read_address   (read_address),
      .rd_buffer_sel  (rd_buffer_sel),
      .request_write  (request_write),
      .write_address  (write_address),
      .wr_buffer_sel  (wr_buffer_sel),
      .clear_err      (clear_err),
      .mem_ack        (mem_ack),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .buf_sel        (buf_sel),
      .line_idx       (line_idx),
      .fill_we        (fill_we),
      .making_request (making_request),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int fill_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- Behavioural model ----------------
   // Each accepted transfer becomes eight expected line records. The head of
   // the queue is what memory must be seeing; an acknowledge retires it.
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic        sel;
      int          idx;
   } line_t;

   line_t       q[$];
   logic        m_rd_v = 1'b0, m_wr_v = 1'b0, m_ovr = 1'b0;
   logic [31:0] m_rd_a = '0, m_wr_a = '0;
   logic        m_rd_s = 1'b0, m_wr_s = 1'b0;

   task automatic push_xfer(input logic we, input logic [31:0] a, input logic sel);
      logic [31:0] base;
      base = a & ~32'(LB - 1);
      for (int i = 0; i < BL; i++) begin
         line_t l;
         l.we   = we;
         l.addr = base + 32'(i * LB);
         l.sel  = sel;
         l.idx  = i;
         q.push_back(l);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         q.delete();
         m_rd_v = 1'b0;
         m_wr_v = 1'b0;
         m_ovr  = 1'b0;
      end else begin
         logic old_rd, old_wr, set_o;
         old_rd = m_rd_v;
         old_wr = m_wr_v;
         set_o  = (request_read && old_rd) || (request_write && old_wr);
         if (q.size() != 0 && mem_ack) void'(q.pop_front());
         if (q.size() == 0) begin
            if (old_wr) begin
               push_xfer(1'b1, m_wr_a, m_wr_s);
               m_wr_v = 1'b0;
            end else if (old_rd) begin
               push_xfer(1'b0, m_rd_a, m_rd_s);
               m_rd_v = 1'b0;
            end
         end
         if (request_read && !old_rd) begin
            m_rd_v = 1'b1; m_rd_a = read_address; m_rd_s = rd_buffer_sel;
         end
         if (request_write && !old_wr) begin
            m_wr_v = 1'b1; m_wr_a = write_address; m_wr_s = wr_buffer_sel;
         end
         if (set_o) m_ovr = 1'b1;
         else if (clear_err) m_ovr = 1'b0;
      end
   end

   // ---------------- Per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("mem_req", mem_req, q.size() != 0);
         if (q.size() != 0) begin
            chk("mem_we",   mem_we,   q[0].we);
            chk("mem_addr", mem_addr, q[0].addr);
            chk("buf_sel",  buf_sel,  q[0].sel);
            chk("line_idx", line_idx, q[0].idx);
            chk("fill_we",  fill_we,  !q[0].we && mem_ack);
         end else begin
            chk("fill_we_idle", fill_we, 1'b0);
         end
         chk("making_request", making_request, (q.size() != 0) || m_rd_v || m_wr_v);
         chk("overrun", overrun, m_ovr);
         if (fill_we) fill_cnt++;
      end
   end

   // ---------------- Stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (!making_request) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      chk(name, done, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int f0, cnt, found;
      logic [31:0] held;

      rst_n = 1'b0;
      tick(); tick();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_buf_sel", buf_sel, 0);
      chk("rst_line_idx", line_idx, 0);
      chk("rst_fill_we", fill_we, 0);
      chk("rst_making_request", making_request, 0);
      chk("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      tick();

      // Fill of buffer 1, acknowledged every cycle
      f0 = fill_cnt;
      mem_ack = 1'b1;
      request_read = 1'b1; read_address = 32'h2000_0010; rd_buffer_sel = 1'b1;
      tick();
      request_read = 1'b0;
      chk("t1_pending_busy", making_request, 1);
      chk("t1_no_req_yet", mem_req, 0);
      tick();
      chk("t1_first_req", mem_req, 1);
      chk("t1_first_addr", mem_addr, 32'h2000_0000);
      chk("t1_buf_sel", buf_sel, 1);
      chk("t1_fill_we", fill_we, 1);
      repeat (7) tick();
      chk("t1_last_idx", line_idx, 7);
      chk("t1_last_addr", mem_addr, 32'h2000_01C0);
      tick();
      chk("t1_done", making_request, 0);
      chk("t1_fill_pulses", fill_cnt - f0, 8);
      $display("txn fill 0x20000010 sel1 complete");

      // Same-cycle write and read: drain first, fill follows with no gap
      request_read = 1'b1; read_address = 32'h3000_0040; rd_buffer_sel = 1'b1;
      request_write = 1'b1; write_address = 32'h1000_0000; wr_buffer_sel = 1'b0;
      tick();
      request_read = 1'b0; request_write = 1'b0;
      tick();
      chk("t2_write_first", mem_we, 1);
      chk("t2_write_addr", mem_addr, 32'h1000_0000);
      repeat (7) tick();
      chk("t2_write_last", line_idx, 7);
      tick();
      chk("t2_no_gap_req", mem_req, 1);
      chk("t2_read_we", mem_we, 0);
      chk("t2_read_addr", mem_addr, 32'h3000_0040);
      chk("t2_read_sel", buf_sel, 1);
      repeat (8) tick();
      chk("t2_done", making_request, 0);
      mem_ack = 1'b0;
      $display("txn write+read same cycle complete");

      // Slow memory: acknowledge on every fourth cycle
      request_read = 1'b1; read_address = 32'h0000_0100; rd_buffer_sel = 1'b0;
      tick();
      request_read = 1'b0;
      tick();
      cnt = 0;
      held = '0;
      for (int k = 0; k < 32; k++) begin
         mem_ack = (k % 4 == 3);
         if (k % 4 == 0) held = mem_addr;
         else chk("t3_addr_stable", mem_addr, held);
         if (mem_req) cnt++;
         tick();
      end
      mem_ack = 1'b0;
      chk("t3_cycles", cnt, 32);
      chk("t3_done_req", mem_req, 0);
      chk("t3_done_busy", making_request, 0);
      $display("txn slow fill 0x00000100 complete");

      // Overrun: read slot already full while a drain is in progress
      request_write = 1'b1; write_address = 32'h5000_0000; wr_buffer_sel = 1'b0;
      tick();
      request_write = 1'b0;
      tick();
      request_read = 1'b1; read_address = 32'h6000_0080; rd_buffer_sel = 1'b1;
      tick();
      read_address = 32'h7000_0000; rd_buffer_sel = 1'b0;
      tick();
      request_read = 1'b0;
      chk("t4_overrun_set", overrun, 1);
      tick(); tick();
      chk("t4_overrun_sticky", overrun, 1);
      request_read = 1'b1; clear_err = 1'b1;
      tick();
      request_read = 1'b0; clear_err = 1'b0;
      chk("t4_set_beats_clear", overrun, 1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("t4_cleared", overrun, 0);
      mem_ack = 1'b1;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (mem_req && !mem_we) begin
            found = 1;
            break;
         end
      end
      chk("t4_read_started", found, 1);
      chk("t4_kept_first_addr", mem_addr, 32'h6000_0080);
      chk("t4_kept_first_sel", buf_sel, 1);
      wait_idle("t4_idle");
      mem_ack = 1'b0;
      $display("txn overrun sequence complete");

      // Address wrap past 2^32
      mem_ack = 1'b1;
      request_write = 1'b1; write_address = 32'hFFFF_FF80; wr_buffer_sel = 1'b1;
      tick();
      request_write = 1'b0;
      tick();
      chk("t5_addr0", mem_addr, 32'hFFFF_FF80);
      tick();
      chk("t5_addr1", mem_addr, 32'hFFFF_FFC0);
      tick();
      chk("t5_addr2_wrap", mem_addr, 32'h0000_0000);
      wait_idle("t5_idle");
      mem_ack = 1'b0;
      $display("txn wrap write 0xFFFFFF80 complete");

      // Reset in the middle of a fill
      mem_ack = 1'b1;
      request_read = 1'b1; read_address = 32'h4000_0000; rd_buffer_sel = 1'b1;
      tick();
      request_read = 1'b0;
      repeat (4) tick();
      chk("t6_mid_idx", line_idx, 3);
      chk("t6_mid_addr", mem_addr, 32'h4000_00C0);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_req", mem_req, 0);
      chk("t6_rst_busy", making_request, 0);
      chk("t6_rst_idx", line_idx, 0);
      chk("t6_rst_addr", mem_addr, 0);
      chk("t6_rst_fill", fill_we, 0);
      mem_ack = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("t6_no_resume_req", mem_req, 0);
      chk("t6_no_resume_busy", making_request, 0);
      tick();
      chk("t6_still_idle", mem_req, 0);
      $display("txn reset during fill complete");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
